// File: rtl/spi_deserializer_if.sv
// Bundle for the SPI receive lines and the consumer-side word handshake.
// The master modport belongs to whoever drives SPI and acknowledges words.
interface spi_deserializer_if #(
   parameter int DATA_SIZE = 32
);
   logic                 i_CS;
   logic                 i_SCLK;
   logic                 i_MOSI;
   logic                 i_Data_Ack;
   logic [DATA_SIZE-1:0] o_Data;
   logic                 o_Data_Valid;
   logic                 o_Frame_Error;
   logic                 o_Overrun;
   logic                 o_Busy;

   modport master (
      output i_CS, i_SCLK, i_MOSI, i_Data_Ack,
      input  o_Data, o_Data_Valid, o_Frame_Error, o_Overrun, o_Busy
   );

   modport slave (
      input  i_CS, i_SCLK, i_MOSI, i_Data_Ack,
      output o_Data, o_Data_Valid, o_Frame_Error, o_Overrun, o_Busy
   );
endinterface

// File: rtl/spi_deserializer.sv
// Oversampling mode-0, LSB-first SPI receiver: rebuilds DATA_SIZE-bit frames
// and hands them out through a valid/ack holding register.
module spi_deserializer #(
   parameter int DATA_SIZE = 32
) (
   input  logic              i_Clock,
   input  logic              i_Reset_n,
   spi_deserializer_if.slave bus
);

   localparam int CntW = $clog2(DATA_SIZE) + 1;
   localparam logic [CntW-1:0] LastBit   = CntW'(DATA_SIZE - 1);
   localparam logic [CntW-1:0] FullCount = CntW'(DATA_SIZE);
   localparam logic [CntW-1:0] OverCount = CntW'(DATA_SIZE + 1);

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      WAIT_END
   } state_t;

   // Pipe bit 0 is the metastability flop, bit 1 the synchronised value, bit 2 history
   logic [2:0] csPipe_q;
   logic [2:0] sclkPipe_q;
   logic [2:0] mosiPipe_q;
   logic [2:0] chainFill_q;
   logic       csRise_q;
   logic       csFall_q;
   logic       sclkRise_q;

   state_t               state_q, state_d;
   logic [CntW-1:0]      count_q, count_d;
   logic [DATA_SIZE-1:0] shift_q, shift_d;
   logic                 deliverReq_q, deliver_d;
   logic                 frameErr_q, frameErr_d;
   logic [DATA_SIZE-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 overrun_q, overrun_d;
   logic                 busy_q;

   // Reset-valued CS history must not look like a falling edge, hence chainFill_q
   always_ff @(posedge i_Clock) begin
      if (!i_Reset_n) begin
         csPipe_q    <= '1;
         sclkPipe_q  <= '0;
         mosiPipe_q  <= '0;
         chainFill_q <= '0;
         csRise_q    <= 1'b0;
         csFall_q    <= 1'b0;
         sclkRise_q  <= 1'b0;
      end else begin
         csPipe_q    <= {csPipe_q[1:0], bus.i_CS};
         sclkPipe_q  <= {sclkPipe_q[1:0], bus.i_SCLK};
         mosiPipe_q  <= {mosiPipe_q[1:0], bus.i_MOSI};
         chainFill_q <= {chainFill_q[1:0], 1'b1};
         csRise_q    <= csPipe_q[1] & ~csPipe_q[2];
         csFall_q    <= ~csPipe_q[1] & csPipe_q[2] & chainFill_q[2];
         sclkRise_q  <= sclkPipe_q[1] & ~sclkPipe_q[2];
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      shift_d    = shift_q;
      deliver_d  = 1'b0;
      frameErr_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (csFall_q) begin
               count_d = '0;
               shift_d = '0;
               state_d = RECV;
            end
         end
         RECV: begin
            if (csRise_q) begin
               frameErr_d = 1'b1;
               state_d    = IDLE;
            end else if (sclkRise_q) begin
               shift_d = {mosiPipe_q[2], shift_q[DATA_SIZE-1:1]};
               count_d = count_q + CntW'(1);
               if (count_q == LastBit) begin
                  state_d = WAIT_END;
               end
            end
         end
         WAIT_END: begin
            if (csRise_q) begin
               if (count_q == FullCount) begin
                  deliver_d = 1'b1;
               end else begin
                  frameErr_d = 1'b1;
               end
               state_d = IDLE;
            end else if (sclkRise_q) begin
               count_d = OverCount;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A deliver always wins over a same-cycle ack; the ack then only prevents overrun
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      if (deliverReq_q) begin
         data_d    = shift_q;
         valid_d   = 1'b1;
         overrun_d = valid_q & ~bus.i_Data_Ack;
      end else if (bus.i_Data_Ack) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Reset_n) begin
         state_q      <= IDLE;
         count_q      <= '0;
         shift_q      <= '0;
         deliverReq_q <= 1'b0;
         frameErr_q   <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         shift_q      <= shift_d;
         deliverReq_q <= deliver_d;
         frameErr_q   <= frameErr_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         overrun_q    <= overrun_d;
         busy_q       <= (state_d != IDLE);
      end
   end

   assign bus.o_Data        = data_q;
   assign bus.o_Data_Valid  = valid_q;
   assign bus.o_Frame_Error = frameErr_q;
   assign bus.o_Overrun     = overrun_q;
   assign bus.o_Busy        = busy_q;

endmodule

// File: tb/tb_spi_deserializer.sv
// Self-checking bench for spi_deserializer: directed and random frames
// compared against a frame-level reference model.
module tb_spi_deserializer;

   localparam int DS = 32;

   logic clk  = 1'b0;
   logic rstN = 1'b0;

   always #5 clk = ~clk;

   spi_deserializer_if #(.DATA_SIZE(DS)) bus ();

   spi_deserializer #(.DATA_SIZE(DS)) dut (
      .i_Clock   (clk),
      .i_Reset_n (rstN),
      .bus       (bus)
   );

   int checkCount = 0;
   int errorCount = 0;
   int errPulses  = 0;
   int ovrPulses  = 0;
   int expErr     = 0;
   int expOvr     = 0;

   logic [DS-1:0] modelData  = '0;
   logic          modelValid = 1'b0;

   // Pulse outputs are counted once per cycle they are high
   always @(negedge clk) begin
      if (bus.o_Frame_Error === 1'b1) errPulses++;
      if (bus.o_Overrun === 1'b1) ovrPulses++;
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic clockBits(input int n);
      for (int i = 0; i < n; i++) begin
         bus.i_MOSI = 1'($urandom_range(0, 1));
         tick(4);
         bus.i_SCLK = 1'b1;
         tick(4);
         bus.i_SCLK = 1'b0;
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_valid"}, 64'(bus.o_Data_Valid), 64'(modelValid));
      checkOutput({tag, "_data"}, 64'(bus.o_Data), 64'(modelData));
      checkOutput({tag, "_errs"}, 64'(errPulses), 64'(expErr));
      checkOutput({tag, "_ovrs"}, 64'(ovrPulses), 64'(expOvr));
      checkOutput({tag, "_busy"}, 64'(bus.o_Busy), 64'd0);
   endtask

   // One frame of nBits SCLK pulses; word supplies the first DS bits LSB first
   task automatic applyStimulus(input logic [DS-1:0] word, input int nBits,
                                input bit ackInDeliver, input bit coincident,
                                input string tag);
      bit   bits[$];
      int   counted;
      logic validBefore;
      for (int i = 0; i < nBits; i++) begin
         if (i < DS) bits.push_back(word[i]);
         else bits.push_back(1'($urandom_range(0, 1)));
      end
      bus.i_CS = 1'b0;
      tick(4);
      checkOutput({tag, "_busy_start"}, 64'(bus.o_Busy), 64'd1);
      for (int i = 0; i < nBits; i++) begin
         bus.i_MOSI = bits[i];
         tick(4);
         bus.i_SCLK = 1'b1;
         if (coincident && i == nBits - 1) break;
         tick(4);
         bus.i_SCLK = 1'b0;
      end
      if (!coincident) tick(4);
      bus.i_CS = 1'b1;
      validBefore = modelValid;

      counted = coincident ? nBits - 1 : nBits;
      if (counted == DS) begin
         if (modelValid && !ackInDeliver) expOvr++;
         modelData  = word;
         modelValid = 1'b1;
      end else begin
         expErr++;
         if (ackInDeliver) modelValid = 1'b0;
      end

      tick(4);
      checkOutput({tag, "_valid_early"}, 64'(bus.o_Data_Valid), 64'(validBefore));
      if (ackInDeliver) bus.i_Data_Ack = 1'b1;
      tick(1);
      bus.i_Data_Ack = 1'b0;
      checkOutput({tag, "_valid_lat"}, 64'(bus.o_Data_Valid), 64'(modelValid));
      bus.i_SCLK = 1'b0;
      tick(6);
      checkIdle(tag);
   endtask

   task automatic ackWord(input string tag);
      bus.i_Data_Ack = 1'b1;
      tick(1);
      bus.i_Data_Ack = 1'b0;
      modelValid = 1'b0;
      checkOutput({tag, "_ack_valid"}, 64'(bus.o_Data_Valid), 64'd0);
      checkOutput({tag, "_ack_data"}, 64'(bus.o_Data), 64'(modelData));
      tick(1);
   endtask

   initial begin
      logic [DS-1:0] w;
      int            nb;
      bit            ackMode;
      bit            coin;

      bus.i_CS       = 1'b1;
      bus.i_SCLK     = 1'b0;
      bus.i_MOSI     = 1'b0;
      bus.i_Data_Ack = 1'b0;
      tick(3);
      checkOutput("reset_data", 64'(bus.o_Data), 64'd0);
      checkOutput("reset_valid", 64'(bus.o_Data_Valid), 64'd0);
      checkOutput("reset_err", 64'(bus.o_Frame_Error), 64'd0);
      checkOutput("reset_ovr", 64'(bus.o_Overrun), 64'd0);
      checkOutput("reset_busy", 64'(bus.o_Busy), 64'd0);
      rstN = 1'b1;
      tick(4);

      applyStimulus(32'hA5A50F01, DS, 1'b0, 1'b0, "single");
      ackWord("single");

      applyStimulus(32'h00000001, DS, 1'b0, 1'b0, "b2b_a");
      ackWord("b2b_a");
      applyStimulus(32'hFFFFFFFE, DS, 1'b0, 1'b0, "b2b_b");
      ackWord("b2b_b");

      applyStimulus(32'h12345678, DS, 1'b0, 1'b0, "ovr_a");
      applyStimulus(32'h9ABCDEF0, DS, 1'b0, 1'b0, "ovr_b");
      applyStimulus(32'h0F1E2D3C, DS, 1'b1, 1'b0, "collide");
      ackWord("collide");

      applyStimulus(32'h5555AAAA, 5, 1'b0, 1'b0, "short");
      applyStimulus(32'h33CC33CC, DS + 1, 1'b0, 1'b0, "long");

      // Reset mid-frame with CS held low: the tail of the frame must be ignored
      applyStimulus(32'h76543210, DS, 1'b0, 1'b0, "pre_rst");
      bus.i_CS = 1'b0;
      tick(4);
      clockBits(10);
      rstN = 1'b0;
      tick(2);
      rstN = 1'b1;
      modelData  = '0;
      modelValid = 1'b0;
      checkOutput("rst_mid_busy", 64'(bus.o_Busy), 64'd0);
      checkOutput("rst_mid_data", 64'(bus.o_Data), 64'd0);
      clockBits(22);
      tick(4);
      bus.i_CS = 1'b1;
      tick(10);
      checkIdle("rst_tail");
      applyStimulus(32'hCAFEF00D, DS, 1'b0, 1'b0, "after_rst");
      ackWord("after_rst");

      applyStimulus(32'hDEADBEEF, DS, 1'b0, 1'b1, "coincident");

      // A one-clock CS high closes the frame, and its falling edge opens an empty one
      bus.i_CS = 1'b0;
      tick(4);
      clockBits(10);
      bus.i_CS = 1'b1;
      tick(1);
      bus.i_CS = 1'b0;
      tick(8);
      bus.i_CS = 1'b1;
      tick(10);
      expErr += 2;
      checkIdle("glitch");

      for (int k = 0; k < 20; k++) begin
         w       = DS'($urandom);
         nb      = ($urandom_range(0, 9) < 7) ? DS : int'($urandom_range(0, DS + 2));
         ackMode = 1'($urandom_range(0, 1));
         coin    = (nb > 0) && ($urandom_range(0, 7) == 0);
         applyStimulus(w, nb, ackMode, coin, "rand");
         if ($urandom_range(0, 1) == 1) ackWord("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
